// File: rtl/msk_hpc2_sched.sv
// Shares one HPC2 masked AND gadget among NREQ requesters with round-robin issue.
// Results emerge two cycles after issue, tagged with the owning requester index.
module msk_hpc2_sched #(
    parameter int d = 2,
    parameter int NREQ = 4,
    parameter int GAP = 1,
    localparam int hpc2rnd = d * (d - 1) / 2,
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*d-1:0]    req_ina,
    input  logic [NREQ*d-1:0]    req_inb,
    input  logic [NREQ*2-1:0]    req_op,
    input  logic [hpc2rnd-1:0]   rnd,
    input  logic                 rnd_valid,
    output logic                 rnd_ready,
    output logic                 out_valid,
    output logic [IDW-1:0]       out_id,
    output logic [d-1:0]         out,
    output logic                 busy
);

    localparam logic [d-1:0] SHARE0 = {{(d-1){1'b0}}, 1'b1};

    logic [IDW-1:0]     ptr_r;
    logic [IDW-1:0]     winner_s;
    logic [IDW-1:0]     ptr_nxt_s;
    logic [IDW-1:0]     id1_r;
    logic [IDW-1:0]     id2_r;
    logic               found_s;
    logic               hit_s;
    logic               bubble_s;
    logic               issue_s;
    int                 rr_idx_s;
    logic [NREQ-1:0]    gnt_s;
    logic [d-1:0]       a_sel_s;
    logic [d-1:0]       b_sel_s;
    logic [d-1:0]       a_inv_s;
    logic [d-1:0]       b_inv_s;
    logic [d-1:0]       a1_r;
    logic [d-1:0]       gad_ina_s;
    logic [d-1:0]       gad_inb_s;
    logic [d-1:0]       gad_out_s;
    logic [1:0]         op_sel_s;
    logic [hpc2rnd-1:0] gad_rnd_s;
    logic               v1_r;
    logic               v2_r;
    logic               rinv1_r;
    logic               rinv2_r;

    // Round-robin search: first pending requester at or after the pointer.
    always_comb begin
        winner_s = '0;
        found_s  = 1'b0;
        rr_idx_s = 0;
        hit_s    = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            rr_idx_s = (int'(ptr_r) + k) % NREQ;
            hit_s    = !found_s && req_valid[rr_idx_s];
            winner_s = hit_s ? IDW'(rr_idx_s) : winner_s;
            found_s  = found_s | hit_s;
        end
    end

    // One-hot grant and operand/op selection for the winning requester.
    always_comb begin
        gnt_s    = '0;
        a_sel_s  = '0;
        b_sel_s  = '0;
        op_sel_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            gnt_s[i] = (winner_s == IDW'(i));
            a_sel_s  = a_sel_s | ({d{gnt_s[i]}} & req_ina[i*d +: d]);
            b_sel_s  = b_sel_s | ({d{gnt_s[i]}} & req_inb[i*d +: d]);
            op_sel_s = op_sel_s | ({2{gnt_s[i]}} & req_op[i*2 +: 2]);
        end
    end

    // NOR/OR are built from AND of complemented operands (De Morgan); complement = flip share 0.
    assign a_inv_s   = a_sel_s ^ (op_sel_s[1] ? SHARE0 : '0);
    assign b_inv_s   = b_sel_s ^ (op_sel_s[1] ? SHARE0 : '0);
    assign bubble_s  = (GAP != 0) && v1_r && (id1_r != winner_s);
    assign issue_s   = !rst && found_s && rnd_valid && !bubble_s;
    assign ptr_nxt_s = (int'(winner_s) == NREQ - 1) ? '0 : winner_s + IDW'(1);

    // Arbitration pointer and two-stage result tag pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r   <= '0;
            v1_r    <= 1'b0;
            id1_r   <= '0;
            a1_r    <= '0;
            rinv1_r <= 1'b0;
            v2_r    <= 1'b0;
            id2_r   <= '0;
            rinv2_r <= 1'b0;
        end else begin
            if (issue_s) begin
                ptr_r <= ptr_nxt_s;
            end else begin
                ptr_r <= ptr_r;
            end
            v1_r    <= issue_s;
            id1_r   <= issue_s ? winner_s : '0;
            a1_r    <= issue_s ? a_inv_s : '0;
            rinv1_r <= issue_s & op_sel_s[0];
            v2_r    <= v1_r;
            id2_r   <= id1_r;
            rinv2_r <= rinv1_r;
        end
    end

    assign req_ready = issue_s ? gnt_s : '0;
    assign rnd_ready = issue_s;
    assign gad_inb_s = issue_s ? b_inv_s : '0;
    assign gad_rnd_s = issue_s ? rnd : '0;
    assign gad_ina_s = a1_r;

    MSKand_hpc2 #(.d(d)) u_gadget (
        .clk (clk),
        .ina (gad_ina_s),
        .inb (gad_inb_s),
        .rnd (gad_rnd_s),
        .out (gad_out_s)
    );

    assign out_valid = !rst && v2_r;
    assign out_id    = out_valid ? id2_r : '0;
    assign out       = out_valid ? (gad_out_s ^ (rinv2_r ? SHARE0 : '0)) : '0;
    assign busy      = !rst && (v1_r || v2_r);

endmodule

// HPC2 masked AND: b and randomness enter at cycle t, a at t+1, result shares at t+2.
// Diagonal terms of the product matrix carry a_i*b_i; off-diagonal pairs share one random bit.
module MSKand_hpc2 #(
    parameter int d = 2,
    localparam int hpc2rnd = d * (d - 1) / 2
) (
    input  logic               clk,
    input  logic [d-1:0]       ina,
    input  logic [d-1:0]       inb,
    input  logic [hpc2rnd-1:0] rnd,
    output logic [d-1:0]       out
);

    logic [d-1:0] u_r  [d];
    logic [d-1:0] r_r  [d];
    logic [d-1:0] pa_r [d];
    logic [d-1:0] pn_r [d];

    function automatic logic pair_rnd(input logic [hpc2rnd-1:0] r, input int i, input int j);
        int lo;
        int hi;
        logic [hpc2rnd-1:0] sh;
        logic pick;
        lo   = (i < j) ? i : j;
        hi   = (i < j) ? j : i;
        sh   = '0;
        pick = 1'b0;
        if (i != j) begin
            sh   = r >> (lo * d - lo * (lo + 1) / 2 + hi - lo - 1);
            pick = sh[0];
        end else begin
            pick = 1'b0;
        end
        return pick;
    endfunction

    // Stage 1: blind b with pairwise randomness; keep randomness for the complement term.
    always_ff @(posedge clk) begin
        for (int i = 0; i < d; i++) begin
            for (int j = 0; j < d; j++) begin
                r_r[i][j] <= pair_rnd(rnd, i, j);
                u_r[i][j] <= inb[j] ^ pair_rnd(rnd, i, j);
            end
        end
    end

    // Stage 2: partial products registered separately to stop glitch leakage across shares.
    always_ff @(posedge clk) begin
        for (int i = 0; i < d; i++) begin
            for (int j = 0; j < d; j++) begin
                pa_r[i][j] <= ina[i] & u_r[i][j];
                pn_r[i][j] <= ~ina[i] & r_r[i][j];
            end
        end
    end

    // Compress each row into its output share.
    always_comb begin
        out = '0;
        for (int i = 0; i < d; i++) begin
            out[i] = ^(pa_r[i] ^ pn_r[i]);
        end
    end

endmodule

// File: tb/tb_msk_hpc2_sched.sv
// Bench for msk_hpc2_sched: GAP=0 and GAP=1 instances share stimulus, each checked
// every cycle against a timeline model of issue/arbitration/result.
module tb_msk_hpc2_sched;

    localparam int D  = 2;
    localparam int NR = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req_valid;
    logic [NR*D-1:0]   req_ina;
    logic [NR*D-1:0]   req_inb;
    logic [NR*2-1:0]   req_op;
    logic [0:0]        rnd;
    logic              rnd_valid;

    logic [NR-1:0]     rr_w   [2];
    logic              rnr_w  [2];
    logic              ov_w   [2];
    logic [1:0]        id_w   [2];
    logic [D-1:0]      out_w  [2];
    logic              busy_w [2];

    msk_hpc2_sched #(.d(D), .NREQ(NR), .GAP(0)) dut0 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rr_w[0]),
        .req_ina(req_ina), .req_inb(req_inb), .req_op(req_op), .rnd(rnd),
        .rnd_valid(rnd_valid), .rnd_ready(rnr_w[0]), .out_valid(ov_w[0]),
        .out_id(id_w[0]), .out(out_w[0]), .busy(busy_w[0])
    );

    msk_hpc2_sched #(.d(D), .NREQ(NR), .GAP(1)) dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rr_w[1]),
        .req_ina(req_ina), .req_inb(req_inb), .req_op(req_op), .rnd(rnd),
        .rnd_valid(rnd_valid), .rnd_ready(rnr_w[1]), .out_valid(ov_w[1]),
        .out_id(id_w[1]), .out(out_w[1]), .busy(busy_w[1])
    );

    always #5 clk = ~clk;

    int n_tests;
    int n_fail;

    // model state per instance (g=0: GAP=0, g=1: GAP=1)
    int m_p [2];
    int m_last [2];
    int h1v [2], h1id [2], h1res [2];
    int h2v [2], h2id [2], h2res [2];
    int pend_iss [2], pend_w [2], pend_res [2];
    int e_rr [2], e_rnr [2], e_ov [2], e_id [2], e_res [2], e_busy [2];

    // values sampled from the DUTs in the last step
    int smp_rr [2], smp_rnr [2], smp_ov [2], smp_id [2], smp_x [2], smp_busy [2];

    task automatic chk(input string name, input int g, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s[gap%0d] @%0t: got %0d expected %0d", name, g, $time, act, exp);
        end
    endtask

    function automatic int op_result(input int op, input int a, input int b);
        int r;
        case (op)
            0:       r = a & b;
            1:       r = (a & b) ^ 1;
            2:       r = (a | b) ^ 1;
            default: r = a | b;
        endcase
        return r;
    endfunction

    task automatic model_eval(input int g);
        int found, w, idx, bub;
        pend_iss[g] = 0; pend_w[g] = 0; pend_res[g] = 0;
        if (rst) begin
            e_rr[g] = 0; e_rnr[g] = 0; e_ov[g] = 0; e_id[g] = 0; e_res[g] = 0; e_busy[g] = 0;
        end else begin
            found = 0; w = 0;
            for (int k = 0; k < NR; k++) begin
                idx = (m_p[g] + k) % NR;
                if (found == 0 && req_valid[idx]) begin
                    found = 1;
                    w = idx;
                end
            end
            bub = (g == 1 && m_last[g] >= 0 && w != m_last[g]) ? 1 : 0;
            pend_iss[g] = (found == 1 && rnd_valid && bub == 0) ? 1 : 0;
            pend_w[g]   = w;
            pend_res[g] = op_result(int'(req_op[w*2 +: 2]), int'(^req_ina[w*D +: D]),
                                    int'(^req_inb[w*D +: D]));
            e_rr[g]   = pend_iss[g] ? (1 << w) : 0;
            e_rnr[g]  = pend_iss[g];
            e_ov[g]   = h2v[g];
            e_id[g]   = h2v[g] ? h2id[g] : 0;
            e_res[g]  = h2res[g];
            e_busy[g] = (h1v[g] || h2v[g]) ? 1 : 0;
        end
    endtask

    task automatic model_commit(input int g);
        if (rst) begin
            m_p[g] = 0; m_last[g] = -1; h1v[g] = 0; h2v[g] = 0;
        end else begin
            h2v[g] = h1v[g]; h2id[g] = h1id[g]; h2res[g] = h1res[g];
            h1v[g] = pend_iss[g]; h1id[g] = pend_w[g]; h1res[g] = pend_res[g];
            if (pend_iss[g] != 0) m_p[g] = (pend_w[g] + 1) % NR;
            m_last[g] = pend_iss[g] ? pend_w[g] : -1;
        end
    endtask

    // One clock cycle: inputs already driven at the preceding negedge.
    task automatic step();
        rnd = 1'($urandom);
        #2;
        for (int g = 0; g < 2; g++) begin
            model_eval(g);
            smp_rr[g] = int'(rr_w[g]); smp_rnr[g] = int'(rnr_w[g]); smp_ov[g] = int'(ov_w[g]);
            smp_id[g] = int'(id_w[g]); smp_x[g] = int'(^out_w[g]); smp_busy[g] = int'(busy_w[g]);
            chk("req_ready", g, smp_rr[g], e_rr[g]);
            chk("rnd_ready", g, smp_rnr[g], e_rnr[g]);
            chk("out_valid", g, smp_ov[g], e_ov[g]);
            chk("out_id", g, smp_id[g], e_id[g]);
            chk("busy", g, smp_busy[g], e_busy[g]);
            if (e_ov[g] != 0) chk("out_xor", g, smp_x[g], e_res[g]);
            else chk("out_zero", g, int'(out_w[g]), 0);
        end
        @(posedge clk);
        #1;
        for (int g = 0; g < 2; g++) model_commit(g);
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input int op, input int a, input int b);
        logic sa, sb;
        sa = 1'($urandom);
        sb = 1'($urandom);
        req_valid[i]       = 1'b1;
        req_op[i*2 +: 2]   = 2'(op);
        req_ina[i*D +: D]  = {sa ^ a[0], sa};
        req_inb[i*D +: D]  = {sb ^ b[0], sb};
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        step();
        rst = 1'b0;
    endtask

    int ops [4] = '{2, 3, 1, 0};
    int opa [4] = '{0, 0, 1, 1};
    int opb [4] = '{0, 1, 1, 0};
    int opr [4] = '{1, 1, 0, 0};
    int pat_gap [8] = '{1, 0, 4, 0, 1, 1, 1, 1};
    int seq_rr [7]  = '{1, 2, 4, 8, 0, 0, 0};
    int seq_ov [7]  = '{0, 0, 1, 1, 1, 1, 0};
    int seq_id [7]  = '{0, 0, 0, 1, 2, 3, 0};

    initial begin
        n_tests = 0; n_fail = 0;
        rst = 1'b1; req_valid = '0; req_ina = '0; req_inb = '0; req_op = '0;
        rnd = '0; rnd_valid = 1'b0;
        for (int g = 0; g < 2; g++) begin
            m_p[g] = 0; m_last[g] = -1; h1v[g] = 0; h2v[g] = 0;
            h1id[g] = 0; h2id[g] = 0; h1res[g] = 0; h2res[g] = 0;
        end
        @(negedge clk);
        repeat (2) step();
        chk("rst_ready", 0, smp_rr[0], 0);
        chk("rst_busy", 0, smp_busy[0], 0);
        chk("rst_ov", 0, smp_ov[0], 0);
        rst = 1'b0;

        // single AND from requester 0
        set_req(0, 0, 1, 1);
        req_ina[1:0] = 2'b10; req_inb[1:0] = 2'b01;
        rnd_valid = 1'b1;
        step();
        chk("and_grant", 0, smp_rr[0], 1);
        req_valid = '0;
        step();
        chk("and_busy1", 0, smp_busy[0], 1);
        step();
        chk("and_ov", 0, smp_ov[0], 1);
        chk("and_id", 0, smp_id[0], 0);
        chk("and_xor", 0, smp_x[0], 1);
        chk("and_busy2", 0, smp_busy[0], 1);
        step();
        chk("and_idle", 0, smp_busy[0], 0);

        // all four requesting from reset, full throughput
        do_reset();
        for (int i = 0; i < NR; i++) set_req(i, int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
                                              int'($urandom_range(0, 1)));
        rnd_valid = 1'b1;
        for (int k = 0; k < 7; k++) begin
            step();
            chk("rr4_grant", 0, smp_rr[0], seq_rr[k]);
            chk("rr4_ov", 0, smp_ov[0], seq_ov[k]);
            chk("rr4_id", 0, smp_id[0], seq_id[k]);
            req_valid = req_valid & ~4'(smp_rr[0]);
        end

        // randomness starvation
        do_reset();
        set_req(1, 0, 1, 1);
        rnd_valid = 1'b0;
        repeat (3) begin
            step();
            chk("norand_ready", 0, smp_rr[0], 0);
            chk("norand_rnd", 0, smp_rnr[0], 0);
        end
        rnd_valid = 1'b1;
        step();
        chk("rand_grant", 0, smp_rr[0], 2);
        req_valid = '0;
        step();
        step();
        chk("rand_ov", 0, smp_ov[0], 1);
        chk("rand_id", 0, smp_id[0], 1);

        // every op type with random share splits
        for (int n = 0; n < 4; n++) begin
            do_reset();
            set_req(0, ops[n], opa[n], opb[n]);
            step();
            req_valid = '0;
            step();
            step();
            chk("op_ov", 0, smp_ov[0], 1);
            chk("op_xor", 0, smp_x[0], opr[n]);
        end

        // GAP bubble pattern, then same-requester streaming
        do_reset();
        set_req(0, 0, 1, 1);
        set_req(2, 3, 0, 1);
        for (int k = 0; k < 8; k++) begin
            if (k == 5) req_valid = 4'b0001;
            step();
            chk("gap_pattern", 1, smp_rr[1], pat_gap[k]);
        end

        // reset with an operation in flight
        do_reset();
        set_req(0, 0, 1, 1);
        step();
        chk("flush_grant", 0, smp_rr[0], 1);
        req_valid = '0;
        rst = 1'b1;
        step();
        chk("flush_busy_rst", 0, smp_busy[0], 0);
        rst = 1'b0;
        step();
        chk("flush_ov2", 0, smp_ov[0], 0);
        chk("flush_busy2", 0, smp_busy[0], 0);
        step();
        chk("flush_ov3", 0, smp_ov[0], 0);

        // randomized traffic
        for (int k = 0; k < 600; k++) begin
            rst       = ($urandom_range(0, 59) == 0);
            req_valid = 4'($urandom);
            req_ina   = 8'($urandom);
            req_inb   = 8'($urandom);
            req_op    = 8'($urandom);
            rnd_valid = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
